// File: rtl/if_axi_bridge_if.sv
// Bundle of the fetch-side request/response and AXI4 AR/R signals for if_axi_bridge.
// The master modport is the bridge's view; the slave modport is the fetch stage plus AXI slave.
interface if_axi_bridge_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [1:0]        if_size;
  logic              if_ready;
  logic [1:0]        if_resp;
  logic [DATA_W-1:0] if_data_read;

  logic              axi_ar_valid;
  logic              axi_ar_ready;
  logic [ADDR_W-1:0] axi_ar_addr;
  logic [ID_W-1:0]   axi_ar_id;
  logic [7:0]        axi_ar_len;
  logic [2:0]        axi_ar_size;
  logic [1:0]        axi_ar_burst;

  logic              axi_r_valid;
  logic              axi_r_ready;
  logic [DATA_W-1:0] axi_r_data;
  logic [1:0]        axi_r_resp;
  logic              axi_r_last;
  logic [ID_W-1:0]   axi_r_id;

  modport master (
    input  if_valid, if_addr, if_size,
    output if_ready, if_resp, if_data_read,
    output axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
    input  axi_ar_ready,
    input  axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
    output axi_r_ready
  );

  modport slave (
    output if_valid, if_addr, if_size,
    input  if_ready, if_resp, if_data_read,
    input  axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
    output axi_ar_ready,
    output axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
    input  axi_r_ready
  );
endinterface

// File: rtl/if_axi_bridge.sv
// Instruction fetch to AXI4 read bridge: one single-beat read per fetch request,
// right-justified data returned with a one-cycle if_ready pulse and held afterwards.
module if_axi_bridge #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned AXI_ID = 0
) (
  input logic             clk,
  input logic             rst,
  if_axi_bridge_if.master bus
);
  localparam int unsigned BYTES       = DATA_W / 8;
  localparam int unsigned OFF_W       = $clog2(BYTES);
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic [1:0]        req_size_q;
  logic              holdoff_q;

  logic              ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              r_ready_q, r_ready_d;
  logic              if_ready_q, if_ready_d;
  logic [1:0]        if_resp_q, if_resp_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;

  logic              take_c;
  logic              misaligned_c;
  logic              r_hit_c;
  logic              addr_match_c;
  logic [31:0]       size_bytes_c;
  logic [31:0]       offset_c;
  logic [DATA_W-1:0] data_mask_c;
  logic [DATA_W-1:0] rdata_c;
  logic              unused_r_last;

  // Single-beat reads never need r_last.
  assign unused_r_last = bus.axi_r_last;

  // A request is only accepted in IDLE, and not in the cycle straight after a completion.
  assign take_c       = (state_q == S_IDLE) && bus.if_valid && !holdoff_q;
  assign r_hit_c      = (state_q == S_R) && bus.axi_r_valid && (bus.axi_r_id == ID_W'(AXI_ID));
  assign addr_match_c = bus.if_valid && (bus.if_addr == req_addr_q);

  // Natural alignment and beat-boundary check on the incoming request.
  always_comb begin : align_check
    size_bytes_c = 32'd1 << bus.if_size;
    offset_c     = 32'(bus.if_addr[OFF_W-1:0]);
    misaligned_c = ((offset_c & (size_bytes_c - 32'd1)) != 32'd0) ||
                   ((offset_c + size_bytes_c) > BYTES);
  end

  // Shift the addressed bytes down to bit 0 and zero everything above the access size.
  always_comb begin : extract
    case (req_size_q)
      2'd0:    data_mask_c = DATA_W'(8'hFF);
      2'd1:    data_mask_c = DATA_W'(16'hFFFF);
      2'd2:    data_mask_c = DATA_W'(32'hFFFF_FFFF);
      default: data_mask_c = '1;
    endcase
    rdata_c = (bus.axi_r_data >> {req_addr_q[OFF_W-1:0], 3'b000}) & data_mask_c;
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take_c) state_d = misaligned_c ? S_ERR : S_AR;
      S_AR:    if (bus.axi_ar_ready) state_d = S_R;
      S_R:     if (r_hit_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; completion is decided on the R beat itself
  // so that if_ready appears in the DONE cycle.
  always_comb begin : output_logic
    ar_valid_d = (state_d == S_AR);
    r_ready_d  = (state_d == S_R);
    ar_addr_d  = ar_addr_q;
    if_ready_d = 1'b0;
    if_resp_d  = if_resp_q;
    if_data_d  = if_data_q;
    if (take_c && !misaligned_c) begin
      ar_addr_d = {bus.if_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end
    if (take_c && misaligned_c) begin
      if_ready_d = 1'b1;
      if_resp_d  = RESP_SLVERR;
    end
    if (r_hit_c && addr_match_c) begin
      if_ready_d = 1'b1;
      if_resp_d  = bus.axi_r_resp;
      if_data_d  = rdata_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : out_reg
    if (rst) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      r_ready_q  <= 1'b0;
      if_ready_q <= 1'b0;
      if_resp_q  <= 2'b00;
      if_data_q  <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      r_ready_q  <= r_ready_d;
      if_ready_q <= if_ready_d;
      if_resp_q  <= if_resp_d;
      if_data_q  <= if_data_d;
    end
  end

  // Latched request plus the one-cycle post-completion holdoff.
  always_ff @(posedge clk or posedge rst) begin : req_reg
    if (rst) begin
      req_addr_q <= '0;
      req_size_q <= 2'b00;
      holdoff_q  <= 1'b0;
    end else begin
      holdoff_q <= (state_q == S_DONE) || (state_q == S_ERR);
      if (take_c) begin
        req_addr_q <= bus.if_addr;
        req_size_q <= bus.if_size;
      end
    end
  end

  assign bus.axi_ar_valid = ar_valid_q;
  assign bus.axi_ar_addr  = ar_addr_q;
  assign bus.axi_ar_id    = ID_W'(AXI_ID);
  assign bus.axi_ar_len   = 8'd0;
  assign bus.axi_ar_size  = 3'b011;
  assign bus.axi_ar_burst = 2'b01;
  assign bus.axi_r_ready  = r_ready_q;
  assign bus.if_ready     = if_ready_q;
  assign bus.if_resp      = if_resp_q;
  assign bus.if_data_read = if_data_q;

endmodule
